// File: rtl/awmf_frame_sequencer.sv
// Frame sequencer feeding the AWMF-0165 serial chain driver: packs per-chip words,
// launches frames, tracks the busy handshake and captures readback.
// Optional readback comparison against the previous frame: AWMF_READBACK_CHECK_EN.
module awmf_frame_sequencer #(
    parameter int BUSY_TIMEOUT = 16,
    parameter int DONE_TIMEOUT = 1024,
    parameter int RX_SETTLE    = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic [1:0]   cmd_chip_i,
    input  logic [59:0]  cmd_data_i,
    input  logic [1:0]   cmd_mode_i,
    input  logic         cmd_last_i,
    output logic         tx_en_o,
    output logic [1:0]   tx_mode_o,
    output logic [239:0] tx_data_o,
    input  logic         tx_busy_i,
    input  logic [239:0] rx_data_i,
    output logic [239:0] rb_data_o,
    output logic         frame_done_o,
    output logic         err_timeout_o,
    output logic         err_mode_o,
    output logic         rb_mismatch_o,
    output logic         busy_o
);

    localparam int CW = $clog2(DONE_TIMEOUT + BUSY_TIMEOUT + RX_SETTLE + 2) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE, S_SETTLE, S_CHECK
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [239:0]   buf_q, buf_d, buf_wr;
    logic           tx_en_q, tx_en_d;
    logic [1:0]     tx_mode_q, tx_mode_d;
    logic [239:0]   tx_data_q, tx_data_d;
    logic [239:0]   rb_data_q, rb_data_d;
    logic           frame_done_q, frame_done_d;
    logic           err_timeout_q, err_timeout_d;
    logic           err_mode_q, err_mode_d;
    logic           cmd_ready;

`ifdef AWMF_READBACK_CHECK_EN
    logic [239:0]   prev_frame_q, prev_frame_d;
    logic [1:0]     prev_mode_q, prev_mode_d;
    logic           prev_valid_q, prev_valid_d;
    logic           rb_mismatch_q, rb_mismatch_d;

    function automatic logic [239:0] mode_mask(input logic [1:0] m);
        case (m)
            2'b11:   return {180'b0, {60{1'b1}}};
            2'b10:   return {206'b0, {34{1'b1}}};
            default: return {240{1'b1}};
        endcase
    endfunction
`endif

    always_comb begin
        buf_wr = buf_q;
        buf_wr[cmd_chip_i*60 +: 60] = cmd_data_i;
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        buf_d         = buf_q;
        tx_en_d       = 1'b0;
        tx_mode_d     = tx_mode_q;
        tx_data_d     = tx_data_q;
        rb_data_d     = rb_data_q;
        frame_done_d  = 1'b0;
        err_timeout_d = 1'b0;
        err_mode_d    = 1'b0;
        cmd_ready     = 1'b0;
`ifdef AWMF_READBACK_CHECK_EN
        prev_frame_d  = prev_frame_q;
        prev_mode_d   = prev_mode_q;
        prev_valid_d  = prev_valid_q;
        rb_mismatch_d = 1'b0;
`endif
        case (state_q)
            S_IDLE, S_COLLECT: begin
                cmd_ready = 1'b1;
                if (cmd_valid_i) begin
                    buf_d = buf_wr;
                    if (!cmd_last_i) begin
                        state_d = S_COLLECT;
                    end else if (cmd_mode_i == 2'b00) begin
                        err_mode_d = 1'b1;
                        buf_d      = '0;
                        state_d    = S_IDLE;
                    end else begin
                        // Frame and tx_en are registered together so data is
                        // already stable in the cycle tx_en_o is high.
                        tx_data_d = buf_wr;
                        tx_mode_d = cmd_mode_i;
                        tx_en_d   = 1'b1;
                        cnt_d     = '0;
                        state_d   = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                cnt_d   = cnt_q + CW'(1);
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // cnt_q counts cycles since the tx_en_o cycle; busy beats expiry.
                if (tx_busy_i) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
                    err_timeout_d = 1'b1;
                    buf_d         = '0;
                    state_d       = S_IDLE;
`ifdef AWMF_READBACK_CHECK_EN
                    prev_valid_d  = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy_i) begin
                    // The cycle busy is seen low counts toward the settle time.
                    cnt_d   = CW'(1);
                    state_d = S_SETTLE;
                end else if (cnt_q == CW'(DONE_TIMEOUT - 1)) begin
                    err_timeout_d = 1'b1;
                    buf_d         = '0;
                    state_d       = S_IDLE;
`ifdef AWMF_READBACK_CHECK_EN
                    prev_valid_d  = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SETTLE: begin
                if (int'(cnt_q) + 1 >= RX_SETTLE) begin
                    rb_data_d = rx_data_i;
                    state_d   = S_CHECK;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_CHECK: begin
                frame_done_d = 1'b1;
                buf_d        = '0;
                state_d      = S_IDLE;
`ifdef AWMF_READBACK_CHECK_EN
                if (prev_valid_q && (prev_mode_q == tx_mode_q) &&
                    ((rb_data_q & mode_mask(tx_mode_q)) != prev_frame_q))
                    rb_mismatch_d = 1'b1;
                prev_frame_d = tx_data_q & mode_mask(tx_mode_q);
                prev_mode_d  = tx_mode_q;
                prev_valid_d = 1'b1;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            buf_q         <= '0;
            tx_en_q       <= 1'b0;
            tx_mode_q     <= 2'b00;
            tx_data_q     <= '0;
            rb_data_q     <= '0;
            frame_done_q  <= 1'b0;
            err_timeout_q <= 1'b0;
            err_mode_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            buf_q         <= buf_d;
            tx_en_q       <= tx_en_d;
            tx_mode_q     <= tx_mode_d;
            tx_data_q     <= tx_data_d;
            rb_data_q     <= rb_data_d;
            frame_done_q  <= frame_done_d;
            err_timeout_q <= err_timeout_d;
            err_mode_q    <= err_mode_d;
        end
    end

`ifdef AWMF_READBACK_CHECK_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_frame_q  <= '0;
            prev_mode_q   <= 2'b00;
            prev_valid_q  <= 1'b0;
            rb_mismatch_q <= 1'b0;
        end else begin
            prev_frame_q  <= prev_frame_d;
            prev_mode_q   <= prev_mode_d;
            prev_valid_q  <= prev_valid_d;
            rb_mismatch_q <= rb_mismatch_d;
        end
    end
    assign rb_mismatch_o = rb_mismatch_q;
`else
    assign rb_mismatch_o = 1'b0;
`endif

    assign cmd_ready_o   = cmd_ready & ~rst_i;
    assign tx_en_o       = tx_en_q;
    assign tx_mode_o     = tx_mode_q;
    assign tx_data_o     = tx_data_q;
    assign rb_data_o     = rb_data_q;
    assign frame_done_o  = frame_done_q;
    assign err_timeout_o = err_timeout_q;
    assign err_mode_o    = err_mode_q;
    assign busy_o        = (state_q != S_IDLE) && (state_q != S_COLLECT);

endmodule

// File: tb/tb_awmf_frame_sequencer.sv
// Directed bench for awmf_frame_sequencer with a launch scoreboard and a simple driver model.
module tb_awmf_frame_sequencer;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         cmd_valid_i = 1'b0;
    logic         cmd_ready_o;
    logic [1:0]   cmd_chip_i = '0;
    logic [59:0]  cmd_data_i = '0;
    logic [1:0]   cmd_mode_i = '0;
    logic         cmd_last_i = 1'b0;
    logic         tx_en_o;
    logic [1:0]   tx_mode_o;
    logic [239:0] tx_data_o;
    logic         tx_busy_i = 1'b0;
    logic [239:0] rx_data_i = '0;
    logic [239:0] rb_data_o;
    logic         frame_done_o, err_timeout_o, err_mode_o, rb_mismatch_o, busy_o;

    int total = 0;
    int bad   = 0;
    logic [241:0] sb_q[$];

`ifdef AWMF_READBACK_CHECK_EN
    logic exp_mis_b = 1'b1;
`else
    logic exp_mis_b = 1'b0;
`endif

    awmf_frame_sequencer dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_chip_i(cmd_chip_i), .cmd_data_i(cmd_data_i),
        .cmd_mode_i(cmd_mode_i), .cmd_last_i(cmd_last_i),
        .tx_en_o(tx_en_o), .tx_mode_o(tx_mode_o), .tx_data_o(tx_data_o),
        .tx_busy_i(tx_busy_i), .rx_data_i(rx_data_i), .rb_data_o(rb_data_o),
        .frame_done_o(frame_done_o), .err_timeout_o(err_timeout_o),
        .err_mode_o(err_mode_o), .rb_mismatch_o(rb_mismatch_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [239:0] obs, input logic [239:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] chip, input logic [59:0] data,
                        input logic [1:0] mode, input logic last);
        cmd_valid_i = 1'b1; cmd_chip_i = chip; cmd_data_i = data;
        cmd_mode_i = mode; cmd_last_i = last;
        tick();
        cmd_valid_i = 1'b0; cmd_last_i = 1'b0;
    endtask

    // Call in the cycle right after the last word was accepted.
    task automatic expect_launch(input string tag);
        logic [241:0] e;
        chk({tag, "_tx_en"}, 240'(tx_en_o), 240'(1));
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 240'(1), 240'(0));
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_tx_data"}, tx_data_o, e[239:0]);
            chk({tag, "_tx_mode"}, 240'(tx_mode_o), 240'(e[241:240]));
        end
    endtask

    // Driver model: busy rises 3 cycles after tx_en, stays high hi cycles.
    task automatic handshake(input logic [239:0] rx, input int hi,
                             output int rb_k, output int done_k, output int done_cnt,
                             output logic mism, output logic rdy_seen);
        rb_k = 0; done_k = 0; done_cnt = 0; mism = 1'b0; rdy_seen = 1'b0;
        for (int i = 0; i < 3; i++) begin tick(); rdy_seen |= cmd_ready_o; end
        tx_busy_i = 1'b1; rx_data_i = rx;
        for (int i = 0; i < hi; i++) begin tick(); rdy_seen |= cmd_ready_o; end
        tx_busy_i = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (rb_k == 0 && rb_data_o === rx) rb_k = k;
            if (frame_done_o) begin
                done_cnt++;
                if (done_k == 0) begin done_k = k; mism = rb_mismatch_o; end
            end else if (done_k == 0) begin
                rdy_seen |= cmd_ready_o;
            end
        end
    endtask

    initial begin
        int rb_k, done_k, done_cnt, to_k;
        logic mism, rdy_seen;

        // Reset state
        tick(); tick();
        chk("rst_ready", 240'(cmd_ready_o), 240'(0));
        chk("rst_tx_en", 240'(tx_en_o), 240'(0));
        chk("rst_tx_data", tx_data_o, 240'(0));
        chk("rst_busy", 240'(busy_o), 240'(0));
        rst_i = 1'b0;
        tick();
        chk("post_rst_ready", 240'(cmd_ready_o), 240'(1));

        // 1: two-word chain frame
        send(2'd0, 60'h1, 2'b01, 1'b0);
        sb_q.push_back({2'b01, 60'hABC, 60'h0, 60'h0, 60'h1});
        send(2'd3, 60'hABC, 2'b01, 1'b1);
        expect_launch("f1");
        chk("f1_ready_launch", 240'(cmd_ready_o), 240'(0));
        chk("f1_busy_o", 240'(busy_o), 240'(1));

        // 2: handshake and readback capture
        handshake(240'h5A, 400, rb_k, done_k, done_cnt, mism, rdy_seen);
        chk("f2_rb_lat", 240'(rb_k), 240'(4));
        chk("f2_done_lat", 240'(done_k), 240'(5));
        chk("f2_done_cnt", 240'(done_cnt), 240'(1));
        chk("f2_ready_low", 240'(rdy_seen), 240'(0));
        chk("f2_rb_data", rb_data_o, 240'h5A);
        chk("f2_tx_hold", tx_data_o, {60'hABC, 60'h0, 60'h0, 60'h1});

        // 3: busy never rises
        sb_q.push_back({2'b01, 60'h0, 60'h0, 60'h77, 60'h0});
        send(2'd1, 60'h77, 2'b01, 1'b1);
        expect_launch("f3");
        to_k = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (err_timeout_o) begin to_k = k; break; end
        end
        chk("f3_timeout_lat", 240'(to_k), 240'(16));
        chk("f3_idle", 240'(busy_o), 240'(0));
        chk("f3_ready", 240'(cmd_ready_o), 240'(1));
        chk("f3_tx_kept", tx_data_o, {60'h0, 60'h0, 60'h77, 60'h0});
        sb_q.push_back({2'b01, 60'h0, 60'h0, 60'h0, 60'h5});
        send(2'd0, 60'h5, 2'b01, 1'b1);
        expect_launch("f3b");
        handshake(240'hBEEF, 10, rb_k, done_k, done_cnt, mism, rdy_seen);
        chk("f3b_done_cnt", 240'(done_cnt), 240'(1));
        chk("f3b_no_mis", 240'(mism), 240'(0));

        // 4: mode 00 on last word
        send(2'd2, 60'hDEAD, 2'b01, 1'b0);
        send(2'd1, 60'h99, 2'b00, 1'b1);
        chk("f4_err_mode", 240'(err_mode_o), 240'(1));
        chk("f4_no_tx_en", 240'(tx_en_o), 240'(0));
        tick();
        chk("f4_err_mode_pulse", 240'(err_mode_o), 240'(0));
        sb_q.push_back({2'b10, 60'h0, 60'h0, 60'h0, 60'h7});
        send(2'd0, 60'h7, 2'b10, 1'b1);
        expect_launch("f4b");
        handshake(240'h3C, 20, rb_k, done_k, done_cnt, mism, rdy_seen);
        chk("f4b_done_cnt", 240'(done_cnt), 240'(1));

        // 5: readback comparison across single-serial frames
        sb_q.push_back({2'b11, 180'h0, 60'h123});
        send(2'd0, 60'h123, 2'b11, 1'b1);
        expect_launch("f5a");
        handshake(240'h123, 8, rb_k, done_k, done_cnt, mism, rdy_seen);
        chk("f5a_no_mis", 240'(mism), 240'(0));
        sb_q.push_back({2'b11, 180'h0, 60'h123});
        send(2'd0, 60'h123, 2'b11, 1'b1);
        expect_launch("f5b");
        handshake(240'h124, 8, rb_k, done_k, done_cnt, mism, rdy_seen);
        chk("f5b_mis", 240'(mism), 240'(exp_mis_b));
        sb_q.push_back({2'b11, 180'h0, 60'h123});
        send(2'd0, 60'h123, 2'b11, 1'b1);
        expect_launch("f5c");
        handshake(240'h123, 8, rb_k, done_k, done_cnt, mism, rdy_seen);
        chk("f5c_no_mis", 240'(mism), 240'(0));

        // 6: reset during WAIT_DONE
        sb_q.push_back({2'b01, 60'h1, 180'h0});
        send(2'd3, 60'h1, 2'b01, 1'b1);
        expect_launch("f6");
        repeat (3) tick();
        tx_busy_i = 1'b1;
        repeat (5) tick();
        chk("f6_busy_o", 240'(busy_o), 240'(1));
        rst_i = 1'b1;
        tick();
        chk("f6_tx_data", tx_data_o, 240'(0));
        chk("f6_rb_data", rb_data_o, 240'(0));
        chk("f6_tx_mode", 240'(tx_mode_o), 240'(0));
        chk("f6_pulses", 240'({tx_en_o, frame_done_o, err_timeout_o, err_mode_o, rb_mismatch_o}), 240'(0));
        chk("f6_busy_rst", 240'(busy_o), 240'(0));
        chk("f6_ready_rst", 240'(cmd_ready_o), 240'(0));
        rst_i = 1'b0; tx_busy_i = 1'b0;
        tick();
        chk("f6_ready_after", 240'(cmd_ready_o), 240'(1));
        chk("sb_drained", 240'(sb_q.size()), 240'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
